// File: rtl/radix4_divider_pkg.sv
// Shared definitions for the radix-4 restoring divider: FSM encoding and step count.
package radix4_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int         STEPS     = 8;
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

endpackage

// File: rtl/Hexdisplay.sv
// 7-segment decoder, active-low segments ordered {g,f,e,d,c,b,a}.
module Hexdisplay (
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (digit)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/radix4_div_step.sv
// One radix-4 digit: pick the largest q in 0..3 with q*D <= P' and subtract it.
module radix4_div_step (
    input  logic [9:0] p_prime,
    input  logic [7:0] d,
    output logic [1:0] q,
    output logic [9:0] p_new
);

    logic [9:0] d1;
    logic [9:0] d2;
    logic [9:0] d3;

    // 3*255 = 765 still fits in 10 bits, so no carry is lost here.
    assign d1 = {2'b00, d};
    assign d2 = {1'b0, d, 1'b0};
    assign d3 = d1 + d2;

    always_comb begin
        q     = 2'd0;
        p_new = p_prime;
        if (p_prime >= d3) begin
            q     = 2'd3;
            p_new = p_prime - d3;
        end else if (p_prime >= d2) begin
            q     = 2'd2;
            p_new = p_prime - d2;
        end else if (p_prime >= d1) begin
            q     = 2'd1;
            p_new = p_prime - d1;
        end
    end

endmodule

// File: rtl/radix4_divider.sv
// 16/8 unsigned divider, 2 quotient bits per cycle, with byte-wise operand loading
// and a quotient/remainder display toggle on four 7-segment digits.
module radix4_divider
    import radix4_divider_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in,
    input  logic        getA,
    input  logic        getB,
    input  logic        start,
    input  logic        putOut,
    output logic [15:0] Res,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic        done,
    output logic        divZero
);

    state_t      state;
    state_t      state_next;
    logic [15:0] a;
    logic [7:0]  d;
    logic [9:0]  p;
    logic [15:0] quo;
    logic [2:0]  cnt;
    logic        ptr;
    logic        sel;
    logic        dz_flag;

    logic        load_en;
    logic        go_calc;
    logic        go_zero;
    logic        toggle;

    logic [15:0] a_shift;
    logic [9:0]  p_prime;
    logic [1:0]  step_q;
    logic [9:0]  step_p;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_next;
    end

    // Loads beat start; start beats putOut.
    always_comb begin
        state_next = state;
        load_en    = 1'b0;
        go_calc    = 1'b0;
        go_zero    = 1'b0;
        toggle     = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (getA || getB) begin
                    load_en    = 1'b1;
                    state_next = ST_IDLE;
                end else if (start) begin
                    if (d == 8'd0) begin
                        go_zero    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        go_calc    = 1'b1;
                        state_next = ST_CALC;
                    end
                end else if (state == ST_DONE && putOut) begin
                    toggle = 1'b1;
                end
            end
            ST_CALC: begin
                if (cnt == LAST_STEP) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Dividend consumed MSB-pair first by shifting the step's pair to the top.
    assign a_shift = a << {cnt, 1'b0};
    assign p_prime = (p << 2) | {8'd0, a_shift[15:14]};

    radix4_div_step u_step (
        .p_prime (p_prime),
        .d       (d),
        .q       (step_q),
        .p_new   (step_p)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            a       <= 16'd0;
            d       <= 8'd0;
            p       <= 10'd0;
            quo     <= 16'd0;
            cnt     <= 3'd0;
            ptr     <= 1'b0;
            sel     <= 1'b0;
            dz_flag <= 1'b0;
        end else begin
            if (load_en) begin
                if (getA) begin
                    if (ptr) a[15:8] <= in;
                    else     a[7:0]  <= in;
                    ptr <= ~ptr;
                end
                if (getB) d <= in;
            end
            if (go_calc) begin
                p       <= 10'd0;
                quo     <= 16'd0;
                cnt     <= 3'd0;
                sel     <= 1'b0;
                dz_flag <= 1'b0;
            end
            if (go_zero) begin
                p       <= {2'b00, a[7:0]};
                quo     <= 16'hFFFF;
                cnt     <= 3'd0;
                sel     <= 1'b0;
                dz_flag <= 1'b1;
            end
            if (toggle) sel <= ~sel;
            if (state == ST_CALC) begin
                p   <= step_p;
                quo <= {quo[13:0], step_q};
                cnt <= cnt + 3'd1;
            end
        end
    end

    assign done    = (state == ST_DONE);
    assign divZero = done && dz_flag;

    always_comb begin
        Res = 16'd0;
        if (done) Res = sel ? {8'h00, p[7:0]} : quo;
    end

    Hexdisplay u_hex0 (.digit(Res[3:0]),   .seg(HEX0));
    Hexdisplay u_hex1 (.digit(Res[7:4]),   .seg(HEX1));
    Hexdisplay u_hex2 (.digit(Res[11:8]),  .seg(HEX2));
    Hexdisplay u_hex3 (.digit(Res[15:12]), .seg(HEX3));

endmodule
